// File: rtl/param_seq_gen.sv
// Parametrised stepped sequence generator: even/odd/all modes, up/down, inclusive limit with wrap.
// Optional macro SEQ_GEN_GRAY_EN adds a Gray-coded copy of q on port q_gray.
module param_seq_gen #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             running,
    output logic             wrap
`ifdef SEQ_GEN_GRAY_EN
    ,
    output logic [WIDTH-1:0] q_gray
`endif
);

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] seq_q, seq_d;
    logic [1:0]       mode_q, mode_d;
    logic             wrap_q, wrap_d;

    logic             is_odd, is_all, realign, advance;
    logic [WIDTH:0]   step_w, base_w, limit_w, seq_w, sum_w, floor_w;
    logic [WIDTH-1:0] top_v;

    function automatic logic [WIDTH-1:0] align(input logic [WIDTH-1:0] v,
                                               input logic odd, input logic all);
        logic [WIDTH-1:0] r;
        r = v;
        if (odd)       r[0] = 1'b1;
        else if (!all) r[0] = 1'b0;
        return r;
    endfunction

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            seq_q   <= '0;
            mode_q  <= 2'b00;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            mode_q  <= mode_d;
            wrap_q  <= wrap_d;
        end
    end

    // Next-state logic: stop dominates start
    always_comb begin
        state_d = state_q;
        if (stop)       state_d = S_IDLE;
        else if (start) state_d = S_RUN;
    end

    // Output logic
    always_comb begin
        running = (state_q == S_RUN);
    end

    always_comb begin
        is_odd  = (mode == 2'b01);
        is_all  = (mode == 2'b10);
        step_w  = is_all ? (WIDTH+1)'(1) : (WIDTH+1)'(2);
        base_w  = is_odd ? (WIDTH+1)'(1) : '0;
        limit_w = {1'b0, limit};
        seq_w   = {1'b0, seq_q};
        sum_w   = seq_w + step_w;
        floor_w = base_w + step_w;
        if (is_all)        top_v = limit;
        else if (is_odd)   top_v = limit[0] ? limit : (limit - WIDTH'(1));
        else               top_v = {limit[WIDTH-1:1], 1'b0};
        realign = (mode != mode_q);
        advance = (state_q == S_RUN) && !stop && !load && !realign;
    end

    // Datapath: load > realign > advance; the sum is one bit wider so a full-scale limit still wraps
    always_comb begin
        seq_d  = seq_q;
        mode_d = mode_q;
        wrap_d = 1'b0;
        if (load) begin
            seq_d  = align(load_val, is_odd, is_all);
            mode_d = mode;
        end else if (realign) begin
            seq_d  = align(seq_q, is_odd, is_all);
            mode_d = mode;
        end else if (advance) begin
            if (limit_w < base_w) begin
                seq_d = base_w[WIDTH-1:0];
            end else if (!dir) begin
                if (sum_w > limit_w) begin
                    seq_d  = base_w[WIDTH-1:0];
                    wrap_d = 1'b1;
                end else begin
                    seq_d = sum_w[WIDTH-1:0];
                end
            end else begin
                if (seq_w < floor_w) begin
                    seq_d  = top_v;
                    wrap_d = 1'b1;
                end else begin
                    seq_d = seq_q - step_w[WIDTH-1:0];
                end
            end
        end
    end

    assign q    = seq_q;
    assign qbar = ~seq_q;
    assign wrap = wrap_q;

`ifdef SEQ_GEN_GRAY_EN
    assign q_gray = seq_q ^ (seq_q >> 1);
`endif

endmodule

// File: tb/tb_param_seq_gen.sv
// Bench for param_seq_gen: directed scenarios followed by random traffic against an integer reference model.
module tb_param_seq_gen;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start, stop, dir, load;
    logic [1:0]       mode;
    logic [WIDTH-1:0] load_val, limit;
    logic [WIDTH-1:0] q, qbar;
    logic             running, wrap;
`ifdef SEQ_GEN_GRAY_EN
    logic [WIDTH-1:0] q_gray;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_q, m_mode, m_run, m_wrap;

    param_seq_gen #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .limit    (limit),
        .q        (q),
        .qbar     (qbar),
        .running  (running),
        .wrap     (wrap)
`ifdef SEQ_GEN_GRAY_EN
        ,
        .q_gray   (q_gray)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int m_align(input int v, input int md);
        if (md == 1) return v | 1;
        if (md == 2) return v;
        return v & ~1;
    endfunction

    task automatic model_reset();
        m_q = 0; m_mode = 0; m_run = 0; m_wrap = 0;
    endtask

    // Apply the rules for one clock edge with the inputs as currently driven
    task automatic model_step();
        int md, step, base, top, lim;
        md   = int'(mode);
        lim  = int'(limit);
        step = (md == 2) ? 1 : 2;
        base = (md == 1) ? 1 : 0;
        if (md == 2)      top = lim;
        else if (md == 1) top = (lim % 2 == 1) ? lim : lim - 1;
        else              top = lim - (lim % 2);
        m_wrap = 0;
        if (load) begin
            m_q = m_align(int'(load_val), md);
            m_mode = md;
        end else if (md != m_mode) begin
            m_q = m_align(m_q, md);
            m_mode = md;
        end else if (m_run == 1 && !stop) begin
            if (lim < base) begin
                m_q = base;
            end else if (!dir) begin
                if (m_q + step > lim) begin m_q = base; m_wrap = 1; end
                else m_q = m_q + step;
            end else begin
                if (m_q < base + step) begin m_q = top; m_wrap = 1; end
                else m_q = m_q - step;
            end
        end
        if (stop)       m_run = 0;
        else if (start) m_run = 1;
    endtask

    task automatic check_all();
        chk("q", 32'(q), m_q);
        chk("qbar", 32'(qbar), 32'(~m_q & 15));
        chk("running", 32'(running), m_run);
        chk("wrap", 32'(wrap), m_wrap);
`ifdef SEQ_GEN_GRAY_EN
        chk("q_gray", 32'(q_gray), 32'((m_q ^ (m_q >> 1)) & 15));
`endif
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
        $display("t=%0t start=%b stop=%b load=%b lv=%0d mode=%0d dir=%b lim=%0d -> q=%0d run=%b wrap=%b",
                 $time, start, stop, load, load_val, mode, dir, limit, q, running, wrap);
    endtask

    initial begin
        int exp1[9] = '{0, 2, 4, 6, 8, 10, 12, 14, 0};
        int exp2[5] = '{5, 3, 1, 9, 7};
        rst = 1'b1; start = 0; stop = 0; dir = 0; load = 0;
        mode = 2'b00; load_val = '0; limit = 4'd14;
        model_reset();
        #3;
        check_all();
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        check_all();

        // Even up to 14 and wrap
        start = 1;
        cycle();
        start = 0;
        chk("t1_q0", 32'(q), exp1[0]);
        for (int i = 1; i < 9; i++) begin
            cycle();
            chk("t1_seq", 32'(q), exp1[i]);
        end
        chk("t1_wrap", 32'(wrap), 1);
        stop = 1; cycle(); stop = 0;

        // Odd down with aligned load
        mode = 2'b01; dir = 1; limit = 4'd9; load_val = 4'd6; load = 1;
        cycle();
        load = 0;
        chk("t2_load", 32'(q), 7);
        start = 1; cycle(); start = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t2_seq", 32'(q), exp2[i]);
        end
        stop = 1; cycle(); stop = 0;

        // Realign from even to odd while running
        mode = 2'b00; dir = 0; limit = 4'd14; load_val = 4'd6; load = 1;
        cycle();
        load = 0;
        start = 1; cycle(); start = 0;
        mode = 2'b01;
        cycle(); chk("t3_realign", 32'(q), 7);
        cycle(); chk("t3_step1", 32'(q), 9);
        cycle(); chk("t3_step2", 32'(q), 11);

        // All mode across the full-scale limit
        mode = 2'b10; limit = 4'd15; load_val = 4'd14; load = 1;
        cycle(); load = 0;
        cycle(); chk("t4_15", 32'(q), 15);
        cycle(); chk("t4_wrap_q", 32'(q), 0); chk("t4_wrap", 32'(wrap), 1);
        cycle(); chk("t4_1", 32'(q), 1);

        // Asynchronous reset between edges
        mode = 2'b00; limit = 4'd14; load_val = 4'd10; load = 1;
        cycle(); load = 0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("t5_qbar", 32'(qbar), 15);
        #2 rst = 1'b0;
        cycle(); cycle();
        chk("t5_hold", 32'(q), 0);

        // start+stop together, load with stop
        start = 1; stop = 1; cycle(); start = 0; stop = 0;
        chk("t6_run", 32'(running), 0);
        start = 1; cycle(); start = 0;
        cycle();
        load_val = 4'd5; load = 1; stop = 1;
        cycle(); load = 0; stop = 0;
        chk("t6_lq", 32'(q), 4);
        chk("t6_lrun", 32'(running), 0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            start    = ($urandom_range(0, 7) == 0);
            stop     = ($urandom_range(0, 15) == 0);
            load     = ($urandom_range(0, 15) == 0);
            load_val = WIDTH'($urandom);
            if ($urandom_range(0, 19) == 0) mode  = 2'($urandom);
            if ($urandom_range(0, 9) == 0)  dir   = 1'($urandom);
            if ($urandom_range(0, 29) == 0) limit = WIDTH'($urandom);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/param_seq_gen.md
Name: param_seq_gen

Overview:
- Parametrised successor to the fixed 4-bit even-number generator.
- WIDTH-bit registered sequence generator with run-time mode (even, odd or all numbers), direction (up/down), programmable upper limit with wrap, load and start/stop control.
- Provides true and complemented outputs, like the existing generator.
- Used as a stimulus/address source wherever a bounded stepped count is needed.

Parameters:
- WIDTH, 4, bits of q/qbar/limit/load_val; legal range >= 2.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  IDLE->RUN request.
- stop  input  1  RUN->IDLE request.
- mode  input  2  00 even, 01 odd, 10 all, 11 treated as even.
- dir  input  1  0 count up, 1 count down.
- load  input  1  load load_val into q (parity-aligned).
- load_val  input  WIDTH  value for load.
- limit  input  WIDTH  highest value the sequence may reach (inclusive).
- q  output  WIDTH  current sequence value (registered).
- qbar  output  WIDTH  always ~q.
- running  output  1  1 while FSM in RUN.
- wrap  output  1  one-cycle pulse on the cycle q takes its wrapped value.

Behaviour:
- Reset (async, immediate): q=0, qbar=all ones, running=0, wrap=0, FSM=IDLE, registered mode copy mode_q=00.
- FSM states: IDLE and RUN.
  - IDLE->RUN on start.
  - RUN->IDLE on stop.
  - start and stop in the same cycle: stop wins (IDLE stays IDLE).
- Latency: start sampled at edge N gives running=1 after N. First advance of q happens at edge N+1. stop at edge N gives running=0 after N, and q does not advance at N.
- Per-cycle priority: load > mode-realign > advance.
  - load (any state): q <= align(load_val). No advance that cycle, FSM state unchanged except as set by start/stop.
  - mode-realign: if mode != mode_q, then q <= align(q) and mode_q <= mode. No advance that cycle.
  - advance: only in RUN with neither of the above.
- Step size: 2 in even/odd modes, 1 in all mode.
- align(): even mode clears the LSB; odd mode sets the LSB; all mode is unchanged.
- base = 1 in odd mode, 0 otherwise.
- top = largest value <= limit with the mode's parity:
  - even: limit & ~1.
  - odd: limit if LSB=1, else limit-1.
  - all: limit.
- Up advance:
  - Compute q+step in WIDTH+1 bits.
  - If the sum > limit, q <= base and wrap=1.
  - Else q <= sum.
  - Example: limit = 2^WIDTH-1 must wrap to base, never silently overflow.
- Down advance:
  - If q < base+step, q <= top and wrap=1.
  - Else q <= q-step.
- Out-of-range q (after load or realign, q > limit): the next up-step wraps to base. The next down-step wraps to top only if q < base+step; otherwise it steps down normally.
- Degenerate case, limit < base (odd mode, limit=0): every advance sets q <= base. wrap stays 0.
- wrap deasserts the following cycle unless another wrap occurs.
- stop, load and realign never raise wrap.
- Reset mid-run: all state is cleared asynchronously. Operation resumes only after a new start following rst release.

Optional Feature:
- Macro SEQ_GEN_GRAY_EN.
- Defined: adds output port q_gray (WIDTH) = q ^ (q >> 1), derived combinationally from registered q. At reset q_gray = 0.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=4, limit=14, mode=00, dir=0, start pulse: q = 0,0,2,4,6,8,10,12,14,0. wrap=1 only on the cycle q returns to 0. qbar=~q throughout.
- mode=01, dir=1, limit=9, load load_val=6, then start: q=7 (aligned), then 5,3,1,9 (wrap=1), then 7.
- Running even up at q=6, mode switched to 01: next edge q=7 (realign, no advance), then 9, 11.
- mode=10, limit=15, up, from q=14: q = 15, 0 (wrap=1), 1. No X and no stuck value at the 4-bit overflow.
- Async reset mid-run at q=10 with rst asserted between edges: q=0, qbar=15, running=0, wrap=0 before the next edge. After release, q holds at 0 until start.
- start and stop in the same cycle from IDLE: running stays 0. While running, load=1 together with stop: q = align(load_val) and running=0 next cycle.
